// File: rtl/bcd_entry_to_binary.sv
// Decimal keypad entry: debounced KEY presses shift BCD digits into a 3-digit register,
// a sequential reverse double-dabble converts it to binary on LEDR, digits echo on HEX2..HEX0.
module bcd_entry_to_binary #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       CLOCK_50Mhz,
   input  logic       RESET_N,
   input  logic [3:0] SW,
   input  logic [1:0] KEY,
   output logic [9:0] LEDR,
   output logic [1:0] LEDG,
   output logic [0:6] HEX0,
   output logic [0:6] HEX1,
   output logic [0:6] HEX2
);

   localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    sync1, sync2, deb, deb_prev, press;
   logic [CW-1:0] dcnt [2];

   logic [1:0]  state;
   logic [3:0]  d2, d1, d0;
   logic [1:0]  cnt;
   logic [21:0] sr, sr_next;
   logic [3:0]  iter;
   logic        invalid;
   logic        enter, clear;

   function automatic logic [0:6] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = 7'b1111111;
      endcase
   endfunction

   // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1    <= '1;
         sync2    <= '1;
         deb      <= '1;
         deb_prev <= '1;
         press    <= '0;
         for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
      end else begin
         sync1    <= KEY;
         sync2    <= sync1;
         deb_prev <= deb;
         press    <= deb_prev & ~deb;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == LAST) begin
               deb[i]  <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + CW'(1);
            end
         end
      end
   end

   assign enter = press[0];
   assign clear = press[1];

   always_comb begin
      sr_next = {1'b0, sr[21:1]};
      for (int unsigned k = 0; k < 3; k++) begin
         if (sr_next[10 + 4*k +: 4] >= 4'd8)
            sr_next[10 + 4*k +: 4] = sr_next[10 + 4*k +: 4] - 4'd3;
      end
   end

   always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         d2      <= '0;
         d1      <= '0;
         d0      <= '0;
         cnt     <= '0;
         sr      <= '0;
         iter    <= '0;
         invalid <= 1'b0;
         LEDR    <= '0;
      end else if (clear) begin
         state   <= S_IDLE;
         d2      <= '0;
         d1      <= '0;
         d0      <= '0;
         cnt     <= '0;
         invalid <= 1'b0;
         LEDR    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enter) begin
                  if (SW > 4'd9) begin
                     invalid <= 1'b1;
                  end else begin
                     d2      <= d1;
                     d1      <= d0;
                     d0      <= SW;
                     cnt     <= (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
                     invalid <= 1'b0;
                     state   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               sr    <= {d2, d1, d0, 10'b0};
               iter  <= '0;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               sr   <= sr_next;
               iter <= iter + 4'd1;
               if (iter == 4'd9) state <= S_DONE;
            end
            S_DONE: begin
               LEDR  <= {sr[9:0] > 10'd511, sr[8:0]};
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign LEDG = {invalid, state != S_IDLE};

   always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
      if (!RESET_N) begin
         HEX0 <= '1;
         HEX1 <= '1;
         HEX2 <= '1;
      end else begin
         HEX0 <= (cnt > 2'd0) ? seg(d0) : '1;
         HEX1 <= (cnt > 2'd1) ? seg(d1) : '1;
         HEX2 <= (cnt > 2'd2) ? seg(d2) : '1;
      end
   end

endmodule

// File: tb/tb_bcd_entry_to_binary.sv
// Directed bench for bcd_entry_to_binary with a short debounce window.
module tb_bcd_entry_to_binary;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic [1:0] key;
   logic [9:0] ledr;
   logic [1:0] ledg;
   logic [0:6] hex0, hex1, hex2;

   int n_checks = 0;
   int n_fail   = 0;
   int bc;

   localparam logic [0:6] BLANK = 7'b1111111;
   localparam logic [0:6] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110,
                          G4 = 7'b1001100, G5 = 7'b0100100, G6 = 7'b0100000, G7 = 7'b0001111,
                          G8 = 7'b0000000, G9 = 7'b0000100;

   bcd_entry_to_binary #(.DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50Mhz (clk),
      .RESET_N     (rst_n),
      .SW          (sw),
      .KEY         (key),
      .LEDR        (ledr),
      .LEDG        (ledg),
      .HEX0        (hex0),
      .HEX1        (hex1),
      .HEX2        (hex2)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 10-cycle press of KEY[0]; returns the number of sampled cycles with busy high.
   task automatic enter(input logic [3:0] d, output int busy_cycles);
      sw = d;
      key[0] = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 9) key[0] = 1'b1;
         if (ledg[0]) busy_cycles++;
      end
   endtask

   task automatic clear_digits();
      key[1] = 1'b0;
      tick(10);
      key[1] = 1'b1;
      tick(20);
   endtask

   initial begin
      rst_n = 1'b0;
      key   = 2'b11;
      sw    = 4'd0;
      tick(3);
      check("reset_ledr", ledr, 10'd0);
      check("reset_ledg", ledg, 2'b00);
      check("reset_hex0", hex0, BLANK);
      check("reset_hex1", hex1, BLANK);
      check("reset_hex2", hex2, BLANK);
      rst_n = 1'b1;
      tick(2);

      // 5,1,1 -> 511
      enter(4'd5, bc);
      check("busy_len_5", bc, 12);
      check("one_digit_hex0", hex0, G5);
      check("one_digit_hex1", hex1, BLANK);
      check("one_digit_ledr", ledr, 10'd5);
      enter(4'd1, bc);
      check("busy_len_1a", bc, 12);
      enter(4'd1, bc);
      check("busy_len_1b", bc, 12);
      check("511_hex2", hex2, G5);
      check("511_hex1", hex1, G1);
      check("511_hex0", hex0, G1);
      check("511_ledr", ledr, 10'h1FF);

      // overflow cases
      enter(4'd5, bc);
      enter(4'd1, bc);
      enter(4'd2, bc);
      check("512_ledr", ledr, 10'h200);
      enter(4'd9, bc);
      enter(4'd9, bc);
      enter(4'd9, bc);
      check("999_low9", ledr[8:0], 9'd487);
      check("999_ovf", ledr[9], 1'b1);
      check("999_hex0", hex0, G9);

      // invalid digit
      clear_digits();
      check("clear_ledr", ledr, 10'd0);
      check("clear_hex2", hex2, BLANK);
      enter(4'd7, bc);
      check("7_ledr", ledr, 10'd7);
      enter(4'hC, bc);
      check("inv_busy_len", bc, 0);
      check("inv_ledg", ledg, 2'b10);
      check("inv_hex0", hex0, G7);
      check("inv_hex1", hex1, BLANK);
      check("inv_ledr", ledr, 10'd7);
      enter(4'd3, bc);
      check("73_ledg", ledg, 2'b00);
      check("73_ledr", ledr, 10'd73);
      check("73_hex1", hex1, G7);
      check("73_hex0", hex0, G3);

      // oldest digit drops on the 4th entry
      clear_digits();
      enter(4'd1, bc);
      enter(4'd2, bc);
      enter(4'd3, bc);
      enter(4'd4, bc);
      check("234_hex2", hex2, G2);
      check("234_hex1", hex1, G3);
      check("234_hex0", hex0, G4);
      check("234_ledr", ledr, 10'd234);

      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      enter(4'd6, bc);
      check("6_hex0", hex0, G6);
      check("6_hex1", hex1, BLANK);
      check("6_hex2", hex2, BLANK);
      check("6_ledr", ledr, 10'd6);

      // clear pulse lands mid-conversion
      sw = 4'd2;
      key[0] = 1'b0;
      tick(5);
      key[1] = 1'b0;
      tick(5);
      key[0] = 1'b1;
      tick(2);
      check("abort_busy_before", ledg[0], 1'b1);
      tick(1);
      check("abort_busy_after", ledg[0], 1'b0);
      check("abort_ledr_cleared", ledr, 10'd0);
      tick(2);
      key[1] = 1'b1;
      tick(30);
      check("abort_ledr_kept", ledr, 10'd0);
      check("abort_ledg", ledg, 2'b00);
      check("abort_hex0", hex0, BLANK);
      check("abort_hex1", hex1, BLANK);
      check("abort_hex2", hex2, BLANK);

      // second press during busy is dropped
      enter(4'd8, bc);
      check("8_ledr", ledr, 10'd8);
      sw = 4'd4;
      key[0] = 1'b0;
      tick(4);
      key[0] = 1'b1;
      tick(6);
      sw = 4'd7;
      key[0] = 1'b0;
      tick(4);
      check("busy_mid_ledr", ledr, 10'd8);
      check("busy_mid_flag", ledg[0], 1'b1);
      tick(6);
      key[0] = 1'b1;
      tick(30);
      check("84_ledr", ledr, 10'd84);
      check("84_hex2", hex2, BLANK);
      check("84_hex1", hex1, G8);
      check("84_hex0", hex0, G4);
      check("84_busy", ledg[0], 1'b0);

      // short glitches must not register
      clear_digits();
      sw = 4'd9;
      for (int g = 1; g <= 3; g++) begin
         key[0] = 1'b0;
         tick(g);
         key[0] = 1'b1;
         tick(20);
         check($sformatf("glitch%0d_hex0", g), hex0, BLANK);
      end
      check("glitch_ledr", ledr, 10'd0);
      enter(4'd9, bc);
      check("press10_busy_len", bc, 12);
      check("press10_hex0", hex0, G9);
      check("press10_hex1", hex1, BLANK);
      check("press10_ledr", ledr, 10'd9);

      // asynchronous reset mid-SHIFT
      sw = 4'd5;
      key[0] = 1'b0;
      tick(10);
      key[0] = 1'b1;
      tick(2);
      check("pre_reset_busy", ledg[0], 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_ledr", ledr, 10'd0);
      check("async_ledg", ledg, 2'b00);
      check("async_hex0", hex0, BLANK);
      check("async_hex1", hex1, BLANK);
      check("async_hex2", hex2, BLANK);
      tick(2);
      rst_n = 1'b1;
      tick(30);
      check("post_reset_ledr", ledr, 10'd0);
      check("post_reset_busy", ledg[0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
